// File: rtl/ethernet_tx_buffer.sv
// ethernet_tx_buffer
//   Transmit-side frame buffer between the host bus/DMA and the Ethernet MAC.
//   The host pushes descriptors {length, dest address} and payload bytes into
//   two first-word-fall-through FIFOs. A registered one-cycle transmit_o pulse
//   is raised when a whole frame (head descriptor plus at least that many
//   bytes) is buffered and the MAC reports idle.
// Ports
//   clk_i, rst_n_i                 clock, async active-low reset
//   write_desc_i/desc_address_i/desc_length_i   host descriptor push
//   write_data_i/data_i            host payload byte push
//   desc_full_o, data_full_o       FIFO full flags
//   error_o                        pulse: a push was rejected (full / bad length)
//   transmit_o                     pulse: start a frame
//   read_descriptor_i, read_data_i MAC pops of head descriptor / head byte
//   dest_address_o, payload_length_o, payload_data_o   FWFT head values
//   data_ready_o                   payload FIFO non-empty
//   tx_idle_i                      MAC transmitter idle
//   frames_pending_o               descriptors currently stored
module ethernet_tx_buffer #(
  parameter int DESC_DEPTH = 8,
  parameter int DATA_DEPTH = 2048
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          write_desc_i,
  input  logic [47:0]                   desc_address_i,
  input  logic [15:0]                   desc_length_i,
  input  logic                          write_data_i,
  input  logic [7:0]                    data_i,
  output logic                          desc_full_o,
  output logic                          data_full_o,
  output logic                          error_o,
  output logic                          transmit_o,
  input  logic                          read_descriptor_i,
  input  logic                          read_data_i,
  output logic [5:0][7:0]               dest_address_o,
  output logic [15:0]                   payload_length_o,
  output logic [7:0]                    payload_data_o,
  output logic                          data_ready_o,
  input  logic                          tx_idle_i,
  output logic [$clog2(DESC_DEPTH):0]   frames_pending_o
);
  localparam int DAW = $clog2(DESC_DEPTH);
  localparam int BAW = $clog2(DATA_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  logic [63:0] desc_mem [DESC_DEPTH];
  logic [7:0]  data_mem [DATA_DEPTH];

  // pointers carry one extra MSB so full and empty are distinguishable
  logic [DAW:0] dwp, drp, dwp_n, drp_n;
  logic [BAW:0] bwp, brp, bwp_n, brp_n, bcnt_n;
  logic [15:0]  head_len_n;
  logic         desc_empty, data_empty, len_ok;
  logic         desc_push, desc_pop, data_push, data_pop, frame_ready_n;
  logic [1:0]   state;

  assign desc_empty  = (dwp == drp);
  assign data_empty  = (bwp == brp);
  assign desc_full_o = (dwp[DAW] != drp[DAW]) && (dwp[DAW-1:0] == drp[DAW-1:0]);
  assign data_full_o = (bwp[BAW] != brp[BAW]) && (bwp[BAW-1:0] == brp[BAW-1:0]);

  assign len_ok    = (desc_length_i != 16'd0) && (desc_length_i <= 16'd1500);
  assign desc_push = write_desc_i && !desc_full_o && len_ok;
  assign desc_pop  = read_descriptor_i && !desc_empty;
  assign data_push = write_data_i && !data_full_o;
  assign data_pop  = read_data_i && !data_empty;

  assign dwp_n  = dwp + {{DAW{1'b0}}, desc_push};
  assign drp_n  = drp + {{DAW{1'b0}}, desc_pop};
  assign bwp_n  = bwp + {{BAW{1'b0}}, data_push};
  assign brp_n  = brp + {{BAW{1'b0}}, data_pop};
  assign bcnt_n = bwp_n - brp_n;

  // Frame readiness is evaluated on the post-edge FIFO state so the start
  // pulse can be registered on the same edge that completes the frame.
  // If the descriptor FIFO is empty after this edge's pop, the head is the
  // entry being pushed now (or there is none and the count test fails).
  assign head_len_n    = (dwp == drp_n) ? desc_length_i : desc_mem[drp_n[DAW-1:0]][63:48];
  assign frame_ready_n = (dwp_n != drp_n) && (32'(bcnt_n) >= 32'(head_len_n));

  assign dest_address_o   = desc_mem[drp[DAW-1:0]][47:0];
  assign payload_length_o = desc_mem[drp[DAW-1:0]][63:48];
  assign payload_data_o   = data_mem[brp[BAW-1:0]];
  assign data_ready_o     = !data_empty;
  assign frames_pending_o = dwp - drp;

  // storage arrays: no reset, contents are don't-care while empty
  always_ff @(posedge clk_i) begin
    if (desc_push) desc_mem[dwp[DAW-1:0]] <= {desc_length_i, desc_address_i};
    if (data_push) data_mem[bwp[BAW-1:0]] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dwp <= '0;
      drp <= '0;
      bwp <= '0;
      brp <= '0;
    end else begin
      dwp <= dwp_n;
      drp <= drp_n;
      bwp <= bwp_n;
      brp <= brp_n;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      transmit_o <= 1'b0;
      error_o    <= 1'b0;
    end else begin
      error_o    <= (write_desc_i && !desc_push) || (write_data_i && !data_push);
      transmit_o <= 1'b0;
      case (state)
        S_IDLE: if (frame_ready_n && tx_idle_i) begin
          transmit_o <= 1'b1;
          state      <= S_START;
        end
        // wait for the MAC to acknowledge by dropping idle
        S_START: if (!tx_idle_i) state <= S_BUSY;
        S_BUSY:  if (tx_idle_i)  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ethernet_tx_buffer.sv
module tb_ethernet_tx_buffer;
  localparam int DD = 8;
  localparam int BD = 2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wdesc = 1'b0, wdat = 1'b0, rdesc = 1'b0, rdat = 1'b0, tx_idle = 1'b1;
  logic [47:0] addr = '0;
  logic [15:0] len = '0;
  logic [7:0]  din = '0;
  logic desc_full, data_full, error, transmit, data_ready;
  logic [5:0][7:0] dest_address;
  logic [15:0] payload_length;
  logic [7:0]  payload_data;
  logic [$clog2(DD):0] frames_pending;

  int checks = 0, failures = 0, tx_count = 0;
  int mdesc = 0, mbytes = 0;
  logic [63:0] dq[$];
  logic [7:0]  bq[$];

  ethernet_tx_buffer #(.DESC_DEPTH(DD), .DATA_DEPTH(BD)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .write_desc_i(wdesc), .desc_address_i(addr), .desc_length_i(len),
    .write_data_i(wdat), .data_i(din),
    .desc_full_o(desc_full), .data_full_o(data_full), .error_o(error),
    .transmit_o(transmit),
    .read_descriptor_i(rdesc), .read_data_i(rdat),
    .dest_address_o(dest_address), .payload_length_o(payload_length),
    .payload_data_o(payload_data), .data_ready_o(data_ready),
    .tx_idle_i(tx_idle), .frames_pending_o(frames_pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (transmit === 1'b1) tx_count <= tx_count + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_desc(input logic [47:0] a, input logic [15:0] l);
    logic e;
    e = (mdesc >= DD) || (l == 16'd0) || (l > 16'd1500);
    if (!e) begin dq.push_back({l, a}); mdesc++; end
    wdesc = 1'b1; addr = a; len = l;
    tick();
    wdesc = 1'b0;
    chk("desc_err", error, e);
    chk("frames_pending", frames_pending, mdesc);
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic e;
    e = (mbytes >= BD);
    if (!e) begin bq.push_back(b); mbytes++; end
    wdat = 1'b1; din = b;
    tick();
    wdat = 1'b0;
    chk("byte_err", error, e);
  endtask

  task automatic pop_desc();
    chk("desc_head", {payload_length, dest_address}, dq.pop_front());
    mdesc--;
    rdesc = 1'b1;
    tick();
    rdesc = 1'b0;
  endtask

  task automatic pop_byte();
    chk("byte_head", payload_data, bq.pop_front());
    mbytes--;
    rdat = 1'b1;
    tick();
    rdat = 1'b0;
  endtask

  task automatic reset_state(string tag);
    chk({tag, "_desc_full"}, desc_full, 1'b0);
    chk({tag, "_data_full"}, data_full, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
    chk({tag, "_transmit"}, transmit, 1'b0);
    chk({tag, "_data_ready"}, data_ready, 1'b0);
    chk({tag, "_frames"}, frames_pending, 0);
  endtask

  initial begin
    int t0;
    // reset
    tick(); tick();
    reset_state("rst");
    rst_n = 1'b1;
    tick(); tick(); tick();
    reset_state("post_rst");
    chk("post_rst_txcnt", tx_count, 0);

    // single frame
    push_desc(48'h00_11_22_33_44_55, 16'd3);
    chk("sf_no_tx_desc", transmit, 1'b0);
    push_byte(8'hAA);
    chk("sf_data_ready", data_ready, 1'b1);
    push_byte(8'hBB);
    chk("sf_no_tx_bb", transmit, 1'b0);
    push_byte(8'hCC);
    chk("sf_tx", transmit, 1'b1);
    tick();
    chk("sf_tx_one_cycle", transmit, 1'b0);
    chk("sf_txcnt", tx_count, 1);
    tx_idle = 1'b0; tick();
    pop_desc();
    pop_byte(); pop_byte(); pop_byte();
    tx_idle = 1'b1; tick();
    chk("sf_empty_frames", frames_pending, 0);
    chk("sf_empty_data", data_ready, 1'b0);

    // partial payload
    push_desc(48'hA1_B2_C3_D4_E5_F6, 16'd4);
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    tick(); tick();
    chk("pp_no_tx", tx_count, 1);
    push_byte(8'h04);
    chk("pp_tx", transmit, 1'b1);
    tx_idle = 1'b0; tick();
    pop_desc();
    for (int i = 0; i < 4; i++) pop_byte();
    tx_idle = 1'b1; tick();

    // MAC busy, two queued frames
    tx_idle = 1'b0;
    push_desc(48'h11_11_11_11_11_11, 16'd1);
    push_byte(8'h10);
    push_desc(48'h22_22_22_22_22_22, 16'd2);
    push_byte(8'h20); push_byte(8'h21);
    tick(); tick();
    chk("busy_no_tx", tx_count, 2);
    tx_idle = 1'b1; tick();
    chk("busy_tx_after_idle", transmit, 1'b1);
    tick();
    tx_idle = 1'b0; tick();
    pop_desc(); pop_byte();
    tx_idle = 1'b1; tick();
    chk("b2b_gap_cycle", transmit, 1'b0);
    tick();
    chk("b2b_second_tx", transmit, 1'b1);
    tick();
    tx_idle = 1'b0; tick();
    pop_desc(); pop_byte(); pop_byte();
    tx_idle = 1'b1; tick();
    chk("busy_txcnt", tx_count, 4);

    // descriptor overflow and illegal lengths (MAC held busy)
    tx_idle = 1'b0;
    for (int i = 0; i < DD; i++) push_desc(48'h0A0000000000 + 48'(i), 16'd10 + 16'(i));
    chk("desc_full", desc_full, 1'b1);
    push_desc(48'hDEAD_BEEF_0009, 16'd10);
    tick();
    chk("err_one_cycle", error, 1'b0);
    pop_desc();
    chk("desc_not_full", desc_full, 1'b0);
    push_desc(48'h0, 16'd0);
    push_desc(48'h0, 16'd1501);
    push_desc(48'hBEEF_0000_05DC, 16'd1500);
    while (dq.size() > 0) pop_desc();
    rdesc = 1'b1; tick(); rdesc = 1'b0;
    chk("desc_pop_empty", frames_pending, 0);
    rdat = 1'b1; tick(); rdat = 1'b0;
    chk("data_pop_empty", data_ready, 1'b0);

    // simultaneous push/pop at byte_count = 5
    tx_idle = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i));
    chk("sim_head", payload_data, bq.pop_front());
    bq.push_back(8'h77);
    wdat = 1'b1; din = 8'h77; rdat = 1'b1;
    tick();
    wdat = 1'b0; rdat = 1'b0;
    t0 = tx_count;
    push_desc(48'h55_55_55_55_55_55, 16'd6);
    chk("sim_count5_no_tx", transmit, 1'b0);
    tick(); tick();
    chk("sim_count5_txcnt", tx_count, t0);
    push_byte(8'h99);
    chk("sim_tx_at_6", transmit, 1'b1);
    tx_idle = 1'b0; tick();
    pop_desc();
    for (int i = 0; i < 6; i++) pop_byte();
    tx_idle = 1'b1; tick();

    // fill payload FIFO across the pointer wrap
    tx_idle = 1'b0;
    for (int i = 0; i < BD; i++) push_byte(8'(i) ^ 8'h5A);
    chk("data_full", data_full, 1'b1);
    push_byte(8'hEE);
    pop_byte();
    chk("data_not_full", data_full, 1'b0);
    while (bq.size() > 0) pop_byte();
    chk("fill_drained", data_ready, 1'b0);

    // reset mid-frame discards buffered frames
    push_desc(48'h66_66_66_66_66_66, 16'd2);
    push_byte(8'h01); push_byte(8'h02);
    rst_n = 1'b0;
    #1;
    reset_state("mid_rst");
    dq.delete(); bq.delete(); mdesc = 0; mbytes = 0;
    tick();
    tx_idle = 1'b1;
    rst_n = 1'b1;
    t0 = tx_count;
    tick(); tick(); tick();
    chk("mid_rst_no_tx", tx_count, t0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
